cache_control_nway: RTL
=======================

Name: cache_control_nway

Overview:
Parametrised N-way set-associative, write-back, write-allocate cache controller for the LC-3b memory hierarchy. It is the successor to the 2-way controller. It holds the per-set tree pseudo-LRU state, selects victims (invalid way first), sequences writeback and allocate over the physical-memory handshake, and drives the way-indexed write enables and muxes of the cache datapath. It also keeps saturating hit and miss counters.

Parameters:
WAYS, 4, associativity; power of two, at least 2.
SETS, 8, number of sets; power of two.
IDX_W, $clog2(SETS), set index width.
CNT_W, 16, hit/miss counter width.

Ports:
clk  input  1  clock, rising edge.
rst_n  input  1  asynchronous, active-low reset.
mem_read  input  1  CPU read request; held until mem_resp.
mem_write  input  1  CPU write request; held until mem_resp.
mem_resp  output  1  one-cycle completion pulse to the CPU.
set_index  input  IDX_W  set of the current request.
hit_vec  input  WAYS  per-way tag match AND valid, from the datapath (combinational).
valid_vec  input  WAYS  valid bits of the indexed set.
dirty_vec  input  WAYS  dirty bits of the indexed set.
pmem_read  output  1  line-fill request.
pmem_write  output  1  line-writeback request.
pmem_resp  input  1  physical-memory completion pulse.
way_sel  output  WAYS  one-hot way driving the data/tag output muxes.
data_write  output  WAYS  per-way data array write enable.
tag_write  output  WAYS  per-way tag array write enable.
valid_write  output  WAYS  per-way valid write enable; the written value is 1.
dirty_write  output  WAYS  per-way dirty write enable.
dirty_in  output  1  value written to the dirty array.
datainmux_sel  output  1  0 selects CPU-merged line, 1 selects pmem line.
addrmux_sel  output  1  0 selects CPU address, 1 selects victim tag and set_index (writeback).
hit_cnt  output  CNT_W  saturating hit count.
miss_cnt  output  CNT_W  saturating miss count.

Behaviour:
- States: S_IDLE, S_WRITEBACK, S_ALLOCATE.
- Reset (asynchronous, rst_n=0): state S_IDLE; every output 0; victim register 0; all PLRU bits 0; both counters 0.
- Default value of every output in every state is 0.
- S_IDLE, no request: stay in S_IDLE.
- S_IDLE, request and hit (hit_vec nonzero):
  - Same cycle: mem_resp=1; way_sel = hit way; PLRU of set_index updated; hit_cnt increments.
  - On a write, additionally: data_write = hit way, datainmux_sel=0, dirty_write = hit way, dirty_in=1.
  - Zero-wait-state hit.
- S_IDLE, request and miss:
  - Victim = lowest-index way with valid_vec=0; if all ways are valid, victim = PLRU victim.
  - Victim is latched into a one-hot register.
  - miss_cnt increments once per miss, counted at detection only.
  - Next state: S_WRITEBACK if dirty_vec[victim]=1, else S_ALLOCATE.
- S_WRITEBACK:
  - pmem_write=1, addrmux_sel=1, way_sel = latched victim.
  - Held until pmem_resp, then next state S_ALLOCATE.
- S_ALLOCATE:
  - pmem_read=1, way_sel = latched victim.
  - On the pmem_resp cycle: data_write, tag_write, valid_write, dirty_write = victim; datainmux_sel=1; dirty_in=0. Next state S_IDLE.
  - The request then re-resolves as a hit one cycle later, which is where PLRU is updated and mem_resp is given.
  - The fill itself does not touch PLRU.
- Tree PLRU:
  - WAYS-1 bits per set, stored as a SETS x (WAYS-1) register file.
  - Node 0 is the root; the children of node i are 2i+1 and 2i+2.
  - Bit=0 means the victim lies in the lower-index subtree.
  - On access to way w, every node on w's path is set to point away from w.
  - Victim is found by following the bits from the root.
- Boundary cases:
  - mem_read and mem_write both high: treated as a write.
  - More than one hit_vec bit set: illegal; the lowest-index way is used.
  - Request dropped mid-miss: the fill still completes; no mem_resp is issued.
  - pmem_resp outside S_WRITEBACK/S_ALLOCATE: ignored.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
  - Reset mid-operation: pmem_read/pmem_write drop immediately (asynchronously) and no array write enable asserts.

Test Plan:
- Reset; read set 3 with valid_vec=0000, hit_vec=0000 -> pmem_read=1 in S_ALLOCATE for 5 cycles. On the resp cycle data_write=tag_write=valid_write=0001 and datainmux_sel=1. Next cycle, with hit_vec=0001, mem_resp=1; miss_cnt=1, hit_cnt=1.
- Set 2 all valid and clean; read hits to ways 0,1,2,3 in order -> PLRU bits all 0. A following miss selects way_sel=0001 and goes to S_ALLOCATE.
- Write hit with hit_vec=0100 -> in the same cycle mem_resp=1, data_write=0100, dirty_write=0100, dirty_in=1, datainmux_sel=0.
- Miss with all valid, PLRU victim way 1, dirty_vec=0010 -> S_WRITEBACK with pmem_write=1, addrmux_sel=1, way_sel=0010 until pmem_resp. Then S_ALLOCATE with pmem_read=1, then fill with dirty_in=0, then hit.
- Assert rst_n=0 for half a cycle during S_WRITEBACK -> pmem_write=0 immediately; after release state is S_IDLE, PLRU is cleared, counters are 0.
- CNT_W=4; 20 consecutive read hits -> hit_cnt=15 (saturated), miss_cnt=0.

Source files
------------

// File: rtl/cache_control_nway.sv
// N-way set-associative write-back/write-allocate cache controller with tree PLRU,
// victim selection (invalid way first), writeback/allocate sequencing and hit/miss counters.
module cache_control_nway #(
   parameter int WAYS  = 4,
   parameter int SETS  = 8,
   parameter int IDX_W = $clog2(SETS),
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             mem_read,
   input  logic             mem_write,
   output logic             mem_resp,
   input  logic [IDX_W-1:0] set_index,
   input  logic [WAYS-1:0]  hit_vec,
   input  logic [WAYS-1:0]  valid_vec,
   input  logic [WAYS-1:0]  dirty_vec,
   output logic             pmem_read,
   output logic             pmem_write,
   input  logic             pmem_resp,
   output logic [WAYS-1:0]  way_sel,
   output logic [WAYS-1:0]  data_write,
   output logic [WAYS-1:0]  tag_write,
   output logic [WAYS-1:0]  valid_write,
   output logic [WAYS-1:0]  dirty_write,
   output logic             dirty_in,
   output logic             datainmux_sel,
   output logic             addrmux_sel,
   output logic [CNT_W-1:0] hit_cnt,
   output logic [CNT_W-1:0] miss_cnt
);

   localparam int LVL   = $clog2(WAYS);
   localparam int NODES = WAYS - 1;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_ALLOCATE} state_t;

   state_t           state_q, state_d;
   logic [WAYS-1:0]  victim_q, victim_d;
   logic [NODES-1:0] plru_q [SETS];
   logic [NODES-1:0] plru_d [SETS];
   logic [CNT_W-1:0] hit_cnt_q, hit_cnt_d;
   logic [CNT_W-1:0] miss_cnt_q, miss_cnt_d;

   logic [LVL-1:0]   hit_idx;
   logic [LVL-1:0]   victim_idx;
   logic             request;

   function automatic logic [LVL-1:0] first_one(input logic [WAYS-1:0] v);
      first_one = '0;
      for (int i = WAYS - 1; i >= 0; i--) begin
         if (v[i]) first_one = LVL'(i);
      end
   endfunction

   // Walk from the root; a 0 bit sends the search to the lower-index child.
   function automatic logic [LVL-1:0] plru_victim(input logic [NODES-1:0] bits);
      int node;
      node = 0;
      for (int l = 0; l < LVL; l++) begin
         node = 2 * node + 1 + int'(bits[node]);
      end
      return LVL'(node - NODES);
   endfunction

   function automatic logic [NODES-1:0] plru_touch(input logic [NODES-1:0] bits,
                                                    input logic [LVL-1:0]   way);
      logic [NODES-1:0] r;
      logic             dir;
      int               node;
      r    = bits;
      node = 0;
      for (int l = 0; l < LVL; l++) begin
         dir     = way[LVL-1-l];
         r[node] = ~dir;
         node    = 2 * node + 1 + int'(dir);
      end
      return r;
   endfunction

   assign request    = mem_read | mem_write;
   assign hit_idx    = first_one(hit_vec);
   assign victim_idx = (valid_vec != '1) ? first_one(~valid_vec)
                                         : plru_victim(plru_q[set_index]);
   assign hit_cnt    = hit_cnt_q;
   assign miss_cnt   = miss_cnt_q;

   // NOTE: every output and next-state value gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      victim_d      = victim_q;
      plru_d        = plru_q;
      hit_cnt_d     = hit_cnt_q;
      miss_cnt_d    = miss_cnt_q;
      mem_resp      = 1'b0;
      pmem_read     = 1'b0;
      pmem_write    = 1'b0;
      way_sel       = '0;
      data_write    = '0;
      tag_write     = '0;
      valid_write   = '0;
      dirty_write   = '0;
      dirty_in      = 1'b0;
      datainmux_sel = 1'b0;
      addrmux_sel   = 1'b0;
      // Outputs are forced low while reset is asserted so no array write can slip through.
      if (rst_n) begin
         case (state_q)
            S_IDLE: begin
               if (request && (hit_vec != '0)) begin
                  mem_resp                = 1'b1;
                  way_sel                 = WAYS'(1) << hit_idx;
                  plru_d[set_index]       = plru_touch(plru_q[set_index], hit_idx);
                  if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + 1'b1;
                  if (mem_write) begin
                     data_write  = WAYS'(1) << hit_idx;
                     dirty_write = WAYS'(1) << hit_idx;
                     dirty_in    = 1'b1;
                  end
               end else if (request) begin
                  victim_d = WAYS'(1) << victim_idx;
                  if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + 1'b1;
                  state_d  = dirty_vec[victim_idx] ? S_WRITEBACK : S_ALLOCATE;
               end
            end
            S_WRITEBACK: begin
               pmem_write  = 1'b1;
               addrmux_sel = 1'b1;
               way_sel     = victim_q;
               if (pmem_resp) state_d = S_ALLOCATE;
            end
            S_ALLOCATE: begin
               pmem_read = 1'b1;
               way_sel   = victim_q;
               if (pmem_resp) begin
                  data_write    = victim_q;
                  tag_write     = victim_q;
                  valid_write   = victim_q;
                  dirty_write   = victim_q;
                  datainmux_sel = 1'b1;
                  state_d       = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // NOTE: state uses non-blocking assignments; the PLRU file is reset because victim choice must be deterministic.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         victim_q   <= '0;
         hit_cnt_q  <= '0;
         miss_cnt_q <= '0;
         for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end else begin
         state_q    <= state_d;
         victim_q   <= victim_d;
         hit_cnt_q  <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
         plru_q     <= plru_d;
      end
   end

endmodule
